// File: rtl/wb_host_pkg.sv
// Shared types and constants for the Wishbone host master.
package wb_host_pkg;

  localparam int WB_DW   = 32;
  localparam int WB_AW   = 32;
  localparam int WB_SELW = 4;

  localparam logic [WB_AW-1:0] WB_ADR_INC = 32'd4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RSP  = 2'd2
  } state_e;

endpackage

// File: rtl/wb_host_master_timeout.sv
// Beat watchdog: counts REQ cycles without ack/err and flags expiry at TIMEOUT-1.
// Instantiated by wb_host_master only when WBM_TIMEOUT_EN is defined.
module wb_host_timeout #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [15:0] TC = 16'(TIMEOUT - 1);

  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == TC);

endmodule

// File: rtl/wb_host_master.sv
// Wishbone B4 classic initiator: single/incrementing-burst commands in, one response per beat out.
// Optional beat timeout enabled by defining WBM_TIMEOUT_EN.
//
// state | meaning
// IDLE  | cmd_ready high, waiting for a command
// REQ   | cyc/stb high, waiting for ack/err (or timeout)
// RSP   | stb low, holding the beat response until rsp_ready
module wb_host_master
  import wb_host_pkg::*;
#(
  parameter int LEN_W   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic               cmd_we,
  input  logic [WB_AW-1:0]   cmd_adr,
  input  logic [WB_DW-1:0]   cmd_dat,
  input  logic [WB_SELW-1:0] cmd_sel,
  input  logic [LEN_W-1:0]   cmd_len,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [WB_DW-1:0]   rsp_dat,
  output logic               rsp_err,
  output logic               rsp_last,
  output logic               wbm_cyc_o,
  output logic               wbm_stb_o,
  output logic               wbm_we_o,
  output logic [WB_SELW-1:0] wbm_sel_o,
  output logic [WB_AW-1:0]   wbm_adr_o,
  output logic [WB_DW-1:0]   wbm_dat_o,
  input  logic [WB_DW-1:0]   wbm_dat_i,
  input  logic               wbm_ack_i,
  input  logic               wbm_err_i
);

  state_e               state_q, state_d;
  logic                 cmd_ready_q, cmd_ready_d;
  logic                 cyc_q, cyc_d;
  logic                 stb_q, stb_d;
  logic                 we_q, we_d;
  logic [WB_SELW-1:0]   sel_q, sel_d;
  logic [WB_AW-1:0]     adr_q, adr_d;
  logic [WB_DW-1:0]     dat_q, dat_d;
  logic [LEN_W-1:0]     beats_left_q, beats_left_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic [WB_DW-1:0]     rsp_dat_q, rsp_dat_d;
  logic                 rsp_err_q, rsp_err_d;
  logic                 rsp_last_q, rsp_last_d;
  logic                 timeout_expired;

`ifdef WBM_TIMEOUT_EN
  wb_host_timeout #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk     (clk),
    .reset   (reset),
    .clr     (state_q != REQ),
    .en      ((state_q == REQ) && !wbm_ack_i && !wbm_err_i),
    .expired (timeout_expired)
  );
`else
  // No watchdog: REQ waits for the slave indefinitely.
  assign timeout_expired = 1'b0 && (TIMEOUT > 0);
`endif

  always_comb begin
    state_d      = state_q;
    cmd_ready_d  = cmd_ready_q;
    cyc_d        = cyc_q;
    stb_d        = stb_q;
    we_d         = we_q;
    sel_d        = sel_q;
    adr_d        = adr_q;
    dat_d        = dat_q;
    beats_left_d = beats_left_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_dat_d    = rsp_dat_q;
    rsp_err_d    = rsp_err_q;
    rsp_last_d   = rsp_last_q;

    unique case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          we_d         = cmd_we;
          adr_d        = cmd_adr;
          dat_d        = cmd_dat;
          sel_d        = cmd_sel;
          beats_left_d = cmd_len;
          cmd_ready_d  = 1'b0;
          cyc_d        = 1'b1;
          stb_d        = 1'b1;
          state_d      = REQ;
        end
      end
      REQ: begin
        // err has priority over ack; a timeout only counts when neither arrives.
        if (wbm_err_i || (timeout_expired && !wbm_ack_i)) begin
          rsp_dat_d   = '0;
          rsp_err_d   = 1'b1;
          rsp_last_d  = 1'b1;
          stb_d       = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = RSP;
        end else if (wbm_ack_i) begin
          rsp_dat_d   = we_q ? '0 : wbm_dat_i;
          rsp_err_d   = 1'b0;
          rsp_last_d  = (beats_left_q == '0);
          stb_d       = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = RSP;
        end
      end
      RSP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          if (rsp_last_q) begin
            cyc_d       = 1'b0;
            cmd_ready_d = 1'b1;
            state_d     = IDLE;
          end else begin
            adr_d        = adr_q + WB_ADR_INC;
            beats_left_d = beats_left_q - 1'b1;
            stb_d        = 1'b1;
            state_d      = REQ;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cmd_ready_q  <= 1'b1;
      cyc_q        <= 1'b0;
      stb_q        <= 1'b0;
      we_q         <= 1'b0;
      sel_q        <= '0;
      adr_q        <= '0;
      dat_q        <= '0;
      beats_left_q <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_dat_q    <= '0;
      rsp_err_q    <= 1'b0;
      rsp_last_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cmd_ready_q  <= cmd_ready_d;
      cyc_q        <= cyc_d;
      stb_q        <= stb_d;
      we_q         <= we_d;
      sel_q        <= sel_d;
      adr_q        <= adr_d;
      dat_q        <= dat_d;
      beats_left_q <= beats_left_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_dat_q    <= rsp_dat_d;
      rsp_err_q    <= rsp_err_d;
      rsp_last_q   <= rsp_last_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign wbm_cyc_o = cyc_q;
  assign wbm_stb_o = stb_q;
  assign wbm_we_o  = we_q;
  assign wbm_sel_o = sel_q;
  assign wbm_adr_o = adr_q;
  assign wbm_dat_o = dat_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_dat   = rsp_dat_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_last  = rsp_last_q;

endmodule

// File: doc/wb_host_master.md
Name: wb_host_master

Overview:
- Wishbone B4 classic initiator: the bus-master end of the WB slave port that user-area peripherals expose (e.g. the counter register block).
- Accepts single or incrementing-burst read/write commands over a valid/ready command channel.
- Drives cyc/stb/we/sel/adr/dat onto the bus and returns one response per beat over a valid/ready response channel.
- Used as the user-area test/bridge master, driven from LA probes or a local sequencer.

Parameters:
- LEN_W, 4, width of the cmd_len field; a burst has cmd_len+1 beats, so up to 16 with the default.
- TIMEOUT, 16, cycles of stb without ack/err before a beat is aborted; used only with WBM_TIMEOUT_EN; legal range 2..65535.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted when valid&ready
- cmd_we  in  1  1=write, 0=read
- cmd_adr  in  32  byte address of the first beat
- cmd_dat  in  32  write data, repeated on every beat (fill)
- cmd_sel  in  4  byte lanes, applied to every beat
- cmd_len  in  LEN_W  beats minus one
- rsp_valid  out  1  per-beat response available
- rsp_ready  in  1  response consumed when valid&ready
- rsp_dat  out  32  read data; 0 for writes and errors
- rsp_err  out  1  beat terminated by err or timeout
- rsp_last  out  1  final response of the command
- wbm_cyc_o  out  1  bus cycle
- wbm_stb_o  out  1  strobe
- wbm_we_o  out  1  write enable
- wbm_sel_o  out  4  byte select
- wbm_adr_o  out  32  address
- wbm_dat_o  out  32  write data
- wbm_dat_i  in  32  read data
- wbm_ack_i  in  1  slave acknowledge
- wbm_err_i  in  1  slave error

Behaviour:
- All outputs are registered.
- Reset (synchronous, active-high, clock clk) values:
  - cmd_ready=1.
  - cyc, stb, we, rsp_valid, rsp_err, rsp_last = 0.
  - sel, adr, dat, rsp_dat = 0.
  - State=IDLE.
- Reset asserted mid-transfer: cyc/stb drop on the next edge and no response is produced.
- FSM, 3 states:
  - IDLE:
    - cmd_ready=1.
    - On cmd_valid: latch we/adr/dat/sel, set beats_left=cmd_len, cmd_ready<=0, cyc<=1, stb<=1, go to REQ.
    - The command is accepted in cycle N and stb is high in cycle N+1.
  - REQ:
    - cyc=stb=1; adr/we/sel/dat held stable.
    - On ack: rsp_dat<=(we?0:wbm_dat_i), rsp_err<=0, stb<=0, rsp_valid<=1, rsp_last<=(beats_left==0); go to RSP.
    - On err: same as ack except rsp_dat<=0, rsp_err<=1, rsp_last<=1.
    - ack and err in the same cycle: err wins.
  - RSP:
    - stb=0; cyc stays 1 for the whole burst.
    - rsp_valid is held until rsp_ready.
    - On handshake with last: rsp_valid<=0, cyc<=0, cmd_ready<=1; go to IDLE.
    - Otherwise: adr<=adr+4 (mod 2^32; 0xFFFFFFFC wraps to 0x00000000), beats_left<=beats_left-1, stb<=1; go to REQ.
- stb is deasserted the cycle after ack, so a slave that re-acks while stb stays high never sees a second access.
- ack/err arriving in IDLE or RSP is ignored.
- An error aborts the remaining beats of the burst.
- Minimum beat period: 2 cycles plus slave latency plus response backpressure.

Optional Feature:
- Macro: WBM_TIMEOUT_EN.
- Defined:
  - A cycle counter is cleared on entry to REQ and increments each REQ cycle without ack/err.
  - When it reaches TIMEOUT-1 with no ack/err, the beat ends as an error: rsp_err=1, rsp_dat=0, rsp_last=1, stb<=0. cyc drops after the response handshake.
  - An ack in the same cycle as expiry wins (normal completion).
- Not defined: no counter exists; REQ waits indefinitely.

Decomposition:
- Package wb_host_pkg holds:
  - state enum {IDLE, REQ, RSP};
  - constant WB_ADR_INC=4;
  - constants WB_DW=32, WB_AW=32, WB_SELW=4.
- One natural sub-module, wb_host_timeout: the counter with clear/enable/expired outputs. Instantiated only under WBM_TIMEOUT_EN.

Test Plan:
- Single read: adr=0x30000000, len=0; slave acks 3 cycles after stb with 0x0000002A -> one response, rsp_dat=0x2A, rsp_err=0, rsp_last=1; stb high exactly until the ack cycle; cyc low after the handshake.
- Write burst: we=1, adr=0x30000010, dat=0xA5A5A5A5, sel=0xF, len=3 -> four stb pulses at 0x10/0x14/0x18/0x1C, wbm_dat_o constant, four responses with rsp_dat=0, last only on the 4th, cyc continuous.
- Response backpressure: read len=1, rsp_ready held low 5 cycles -> rsp_valid/rsp_dat stable, stb low, no second bus access until the handshake.
- Error mid-burst: len=3, err on beat 2 -> responses: beat 1 OK, beat 2 rsp_err=1 with rsp_last=1; no beat 3; back to IDLE.
- Timeout (WBM_TIMEOUT_EN, TIMEOUT=16), slave never acks -> rsp_err=1 exactly 16 cycles after stb rises; same test without the macro -> stb stays high indefinitely.
- Reset mid-burst plus address wrap: adr=0xFFFFFFFC, len=1 -> second beat at 0x00000000; assert reset during beat 2 -> cyc/stb/rsp_valid=0 on the next edge and cmd_ready=1.
